// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared FSM encoding and default widths for the RAM port arbiter
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } arb_state_e;

  localparam int DEF_REQ_COUNT  = 4;
  localparam int DEF_MEM_WIDTH  = 12;
  localparam int DEF_ADDR_WIDTH = 12;

  // Index width that stays legal for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_select.sv
// rtl/mem_port_arbiter_rr_select.sv - round-robin pick of the first set request at or after ptr_i
module rr_select
  import mem_port_arbiter_pkg::*;
#(
  parameter int  N  = DEF_REQ_COUNT,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] idx_o,
  output logic          found_o
);

  int            pos;
  logic [IW-1:0] pos_idx;

  // Scan farthest-first so the candidate nearest the pointer is written last.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      pos     = (int'(ptr_i) + k) % N;
      pos_idx = IW'(pos);
      if (req_i[pos_idx]) begin
        idx_o   = pos_idx;
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one registered-read RAM port
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int REQ_COUNT  = DEF_REQ_COUNT,
  parameter int MEM_WIDTH  = DEF_MEM_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [REQ_COUNT-1:0]            req_valid,
  input  logic [REQ_COUNT-1:0]            req_write,
  input  logic [ADDR_WIDTH*REQ_COUNT-1:0] req_addr,
  input  logic [MEM_WIDTH*REQ_COUNT-1:0]  req_wdata,
  output logic [REQ_COUNT-1:0]            req_ready,
  output logic [REQ_COUNT-1:0]            rsp_valid,
  output logic [MEM_WIDTH-1:0]            rsp_rdata,
  output logic [ADDR_WIDTH-1:0]           mem_address,
  output logic [MEM_WIDTH-1:0]            mem_datain,
  output logic                            mem_write,
  input  logic [MEM_WIDTH-1:0]            mem_dataout
);

  localparam int            IW       = idx_width(REQ_COUNT);
  localparam logic [IW-1:0] LAST_IDX = IW'(REQ_COUNT - 1);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] g_q, g_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] sel_idx;
  logic          sel_found;

  rr_select #(.N(REQ_COUNT)) u_rr_select (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .idx_o   (sel_idx),
    .found_o (sel_found)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      g_q      <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      g_q      <= g_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Outputs decode straight from state so an asynchronous reset clears them at once.
  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    rr_ptr_d    = rr_ptr_q;
    req_ready   = '0;
    rsp_valid   = '0;
    rsp_rdata   = '0;
    mem_address = '0;
    mem_datain  = '0;
    mem_write   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          g_d     = sel_idx;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        mem_address    = req_addr[g_q*ADDR_WIDTH +: ADDR_WIDTH];
        mem_datain     = req_wdata[g_q*MEM_WIDTH +: MEM_WIDTH];
        mem_write      = req_write[g_q];
        req_ready[g_q] = 1'b1;
        rr_ptr_d       = (g_q == LAST_IDX) ? '0 : g_q + 1'b1;
        state_d        = req_write[g_q] ? ST_IDLE : ST_RESP;
      end
      ST_RESP: begin
        rsp_valid[g_q] = 1'b1;
        rsp_rdata      = mem_dataout;
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int N  = 4;
  localparam int MW = 12;
  localparam int AW = 12;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid, req_write, req_ready, rsp_valid;
  logic [AW*N-1:0] req_addr;
  logic [MW*N-1:0] req_wdata;
  logic [MW-1:0]   rsp_rdata, mem_datain, mem_dataout;
  logic [AW-1:0]   mem_address;
  logic            mem_write;

  always #5 clk = ~clk;

  mem_port_arbiter #(.REQ_COUNT(N), .MEM_WIDTH(MW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .mem_address(mem_address),
    .mem_datain(mem_datain), .mem_write(mem_write), .mem_dataout(mem_dataout)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // External RAM: registered read, write on the same edge.
  logic [MW-1:0] ram [0:255];
  logic          ram_clear;
  always @(posedge clk) begin
    if (ram_clear) begin
      for (int k = 0; k < 256; k++) ram[k] <= '0;
    end else if (mem_write) begin
      ram[mem_address[7:0]] <= mem_datain;
    end
    mem_dataout <= ram[mem_address[7:0]];
  end

  task automatic set_req(input int i, input logic v, input logic we,
                         input logic [AW-1:0] a, input logic [MW-1:0] d);
    req_valid[i]          = v;
    req_write[i]          = we;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*MW +: MW] = d;
  endtask

  // Reference model: timeline of when the port is free, who is next by rotation,
  // and a shadow memory that tracks every accepted write.
  logic          model_on;
  int            cyc, idle_from, rr, gnt, rsp_who;
  logic          iss_pend, rsp_pend, nxt_rsp;
  logic [MW-1:0] rsp_exp;
  logic [MW-1:0] ref_mem [0:255];
  logic [N-1:0]  exp_vec;
  logic [AW-1:0] m_a;
  logic [MW-1:0] m_d;

  always @(negedge clk) begin
    if (!model_on || !reset) begin
      cyc = 0; idle_from = 0; rr = 0; gnt = 0; rsp_who = 0;
      iss_pend = 1'b0; rsp_pend = 1'b0; rsp_exp = '0;
      for (int k = 0; k < 256; k++) ref_mem[k] = '0;
    end else begin
      exp_vec = '0;
      if (iss_pend) exp_vec[gnt] = 1'b1;
      chk("rnd_ready", req_ready, exp_vec);
      if (iss_pend) begin
        m_a = req_addr[gnt*AW +: AW];
        m_d = req_wdata[gnt*MW +: MW];
        chk("rnd_mem_write", mem_write, req_write[gnt]);
        chk("rnd_mem_address", mem_address, m_a);
        chk("rnd_mem_datain", mem_datain, m_d);
      end else begin
        chk("rnd_mem_idle", {mem_write, mem_address, mem_datain}, '0);
      end
      exp_vec = '0;
      if (rsp_pend) exp_vec[rsp_who] = 1'b1;
      chk("rnd_rsp_valid", rsp_valid, exp_vec);
      chk("rnd_rsp_rdata", rsp_rdata, rsp_pend ? rsp_exp : '0);

      nxt_rsp = 1'b0;
      if (iss_pend) begin
        rr = (gnt + 1) % N;
        if (req_write[gnt]) begin
          ref_mem[m_a[7:0]] = m_d;
          idle_from = cyc + 1;
        end else begin
          nxt_rsp   = 1'b1;
          rsp_who   = gnt;
          rsp_exp   = ref_mem[m_a[7:0]];
          idle_from = cyc + 2;
        end
        iss_pend = 1'b0;
      end else if (cyc >= idle_from && req_valid != '0) begin
        for (int k = 0; k < N; k++) begin
          if (!iss_pend && req_valid[(rr + k) % N]) begin
            gnt      = (rr + k) % N;
            iss_pend = 1'b1;
          end
        end
      end
      rsp_pend = nxt_rsp;
      cyc++;
    end
  end

  typedef struct {
    int            who;
    logic          we;
    logic [AW-1:0] addr;
    logic [MW-1:0] wdata;
    logic [MW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs [7];

  task automatic do_access(input vec_t v);
    int           waited;
    logic         got;
    logic [N-1:0] oh;
    oh = '0;
    oh[v.who] = 1'b1;
    @(posedge clk); #1;
    set_req(v.who, 1'b1, v.we, v.addr, v.wdata);
    waited = 0;
    got    = 1'b0;
    while (waited < 20 && !got) begin
      @(negedge clk);
      waited++;
      if (req_ready != '0) got = 1'b1;
    end
    chk("vec_ready_latency", waited, 2);
    chk("vec_ready", req_ready, oh);
    chk("vec_mem_write", mem_write, v.we);
    chk("vec_mem_address", mem_address, v.addr);
    chk("vec_mem_datain", mem_datain, v.wdata);
    @(posedge clk); #1;
    req_valid[v.who] = 1'b0;
    if (!v.we) begin
      @(negedge clk);
      chk("vec_rsp_valid", rsp_valid, oh);
      chk("vec_rsp_rdata", rsp_rdata, v.exp_rdata);
    end else begin
      chk("vec_ram_update", ram[v.addr[7:0]], v.wdata);
    end
    @(negedge clk);
    chk("vec_quiet_after", {req_ready, rsp_valid}, '0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {req_ready, rsp_valid, rsp_rdata, mem_address, mem_datain, mem_write}, '0);
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    int r = -1;
    for (int k = 0; k < N; k++) if (v[k]) r = k;
    return r;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int            order [5];
    int            n_gr, n3, waited;
    logic          got0, seen;
    logic [N-1:0]  rdy_seen;

    reset = 1'b0; ram_clear = 1'b1; model_on = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    vecs[0] = '{1, 1'b1, 12'h010, 12'hABC, 12'h000};
    vecs[1] = '{2, 1'b0, 12'h010, 12'h000, 12'hABC};
    vecs[2] = '{0, 1'b1, 12'h020, 12'h123, 12'h000};
    vecs[3] = '{3, 1'b0, 12'h020, 12'h000, 12'h123};
    vecs[4] = '{0, 1'b0, 12'h010, 12'h000, 12'hABC};
    vecs[5] = '{2, 1'b1, 12'h010, 12'h5A5, 12'h000};
    vecs[6] = '{1, 1'b0, 12'h010, 12'h000, 12'h5A5};

    repeat (2) @(posedge clk);
    #1 ram_clear = 1'b0;
    req_valid = '1;
    @(negedge clk);
    chk("reset_hold_outputs", {req_ready, rsp_valid, rsp_rdata, mem_address, mem_datain, mem_write}, '0);
    @(posedge clk); #1;
    req_valid = '0;
    reset = 1'b1;

    for (int i = 0; i < 7; i++) do_access(vecs[i]);

    // Everyone requesting: strict rotation from 0, wrapping back to 0.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b1, AW'(12'h040 + i), MW'(i + 1));
    for (int k = 0; k < 5; k++) order[k] = -1;
    n_gr = 0;
    for (int c = 0; c < 40 && n_gr < 5; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        order[n_gr] = onehot_idx(req_ready);
        n_gr++;
      end
    end
    for (int k = 0; k < 5; k++) chk("rr_order", order[k], k % N);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (3) @(posedge clk);

    // A late requester must not be starved by a continuous one.
    do_reset();
    set_req(3, 1'b1, 1'b1, 12'h050, 12'h333);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b1, 12'h051, 12'h111);
    n3 = 0; got0 = 1'b0;
    for (int c = 0; c < 20 && !got0; c++) begin
      @(negedge clk);
      if (req_ready[3]) n3++;
      if (req_ready[0]) got0 = 1'b1;
    end
    chk("starve_granted", got0, 1'b1);
    chk("starve_bound", (n3 <= 1), 1'b1);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (3) @(posedge clk);

    // Reset during the response cycle of a read.
    do_reset();
    set_req(1, 1'b1, 1'b0, 12'h010, 12'h000);
    waited = 0;
    while (waited < 20 && !req_ready[1]) begin
      @(negedge clk);
      waited++;
    end
    chk("rst_read_granted", req_ready[1], 1'b1);
    @(posedge clk); #1;
    req_valid = '0;
    #1 reset = 1'b0;
    #1;
    chk("rst_resp_rsp_valid", rsp_valid, '0);
    chk("rst_resp_rdata", rsp_rdata, '0);
    chk("rst_resp_mem", {mem_write, mem_address, mem_datain, req_ready}, '0);
    @(posedge clk); #1;
    reset = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid != '0) seen = 1'b1;
    end
    chk("rst_no_late_rsp", seen, 1'b0);
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b1, 12'h060, 12'h777);
    set_req(2, 1'b1, 1'b1, 12'h061, 12'h222);
    waited = 0;
    while (waited < 20 && req_ready == '0) begin
      @(negedge clk);
      waited++;
    end
    chk("rst_rr_from_zero", req_ready, 4'b0001);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (3) @(posedge clk);

    // Quiet bus when nobody asks.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("idle_quiet", {mem_write, req_ready, rsp_valid}, '0);
    end

    // Random traffic against the reference model.
    @(posedge clk); #1;
    reset = 1'b0; ram_clear = 1'b1; model_on = 1'b1;
    @(posedge clk); #1;
    ram_clear = 1'b0; reset = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      rdy_seen = req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (rdy_seen[i] || !req_valid[i]) begin
          if ((rdy_seen[i] && $urandom_range(0, 1) == 1) ||
              (!rdy_seen[i] && $urandom_range(0, 2) == 0))
            set_req(i, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), MW'($urandom));
          else
            req_valid[i] = 1'b0;
        end
      end
    end
    req_valid = '0;
    repeat (6) @(posedge clk);
    #1 model_on = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001: Parameter REQ_COUNT, default 4, number of requesters sharing one RAM port.
REQ-002: Parameter MEM_WIDTH, default 12, RAM word width in bits.
REQ-003: Parameter ADDR_WIDTH, default 12, RAM address width in bits.
REQ-004: Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005: Port reset  input  1  asynchronous, active-low reset.
REQ-006: Port req_valid  input  REQ_COUNT  bit i set = requester i has a pending access.
REQ-007: Port req_write  input  REQ_COUNT  bit i: 1 = write, 0 = read.
REQ-008: Port req_addr  input  ADDR_WIDTH*REQ_COUNT  requester i address in slice [(i+1)*ADDR_WIDTH-1 -: ADDR_WIDTH].
REQ-009: Port req_wdata  input  MEM_WIDTH*REQ_COUNT  requester i write data in slice [(i+1)*MEM_WIDTH-1 -: MEM_WIDTH].
REQ-010: Port req_ready  output  REQ_COUNT  one-hot, one-cycle pulse; request i accepted this cycle.
REQ-011: Port rsp_valid  output  REQ_COUNT  one-hot, one-cycle pulse; read data for requester i on rsp_rdata.
REQ-012: Port rsp_rdata  output  MEM_WIDTH  shared read-return bus; valid only while any rsp_valid bit is set.
REQ-013: Port mem_address  output  ADDR_WIDTH  RAM port address.
REQ-014: Port mem_datain  output  MEM_WIDTH  RAM port write data.
REQ-015: Port mem_write  output  1  RAM port write enable.
REQ-016: Port mem_dataout  input  MEM_WIDTH  RAM registered read data, valid the cycle after the address is presented.

Function
REQ-017: FSM states IDLE, ISSUE, RESP; exactly one active.
REQ-018: IDLE: if any req_valid bit set, register grant index g via round-robin, go ISSUE; else stay IDLE.
REQ-019: Round-robin: search starts at rr_ptr, ascending modulo REQ_COUNT; first set req_valid bit wins.
REQ-020: On leaving ISSUE, rr_ptr <= (g+1) mod REQ_COUNT; wrap from REQ_COUNT-1 to 0.
REQ-021: ISSUE: mem_address = req_addr slice g, mem_datain = req_wdata slice g, mem_write = req_write[g], req_ready[g] = 1, for exactly one cycle.
REQ-022: ISSUE -> RESP if req_write[g]=0; ISSUE -> IDLE if req_write[g]=1.
REQ-023: RESP: rsp_valid[g] = 1, rsp_rdata = mem_dataout, for exactly one cycle; then go IDLE.
REQ-024: Latency: write = 2 cycles from IDLE sampling req_valid to RAM update edge; read = rsp_valid 2 cycles after ISSUE entry is granted (IDLE, ISSUE, RESP).
REQ-025: Outside ISSUE, mem_write = 0, mem_address = 0, mem_datain = 0, req_ready = 0.
REQ-026: Outside RESP, rsp_valid = 0 and rsp_rdata = 0.
REQ-027: Requester holds req_valid, req_write, address, data stable until its req_ready pulse; the arbiter samples them only in ISSUE.
REQ-028: If req_valid[g] drops before ISSUE, ISSUE still executes using current slice g values (protocol violation, not detected).
REQ-029: Simultaneous requests: exactly one granted per arbitration; others wait, none is dropped.
REQ-030: A requester re-asserting after its grant waits behind all other pending requesters (no starvation; worst case REQ_COUNT-1 intervening accesses).

Reset
REQ-031: reset low asynchronously forces state IDLE, rr_ptr = 0, g = 0, all outputs 0.
REQ-032: Reset mid-ISSUE or mid-RESP aborts the access; no rsp_valid is produced afterwards for it.
REQ-033: First arbitration occurs on the first rising clk edge after reset deasserts.

Structure
REQ-034: Shared package holds the FSM state encoding (IDLE=2'd0, ISSUE=2'd1, RESP=2'd2) and default width constants.
REQ-035: Round-robin selection is a sub-module rr_select (inputs request vector, pointer; outputs index, found flag).
REQ-036: RAM is external; its write and read paths connect directly to mem_* ports.

Verification
REQ-037: Single write: req 1 writes addr 0x010 data 0xABC -> req_ready[1] one cycle, mem_write=1 that cycle, RAM[0x010]=0xABC.
REQ-038: Read-back: req 2 reads 0x010 -> rsp_valid[2] pulses one cycle later with rsp_rdata=0xABC.
REQ-039: All four req_valid set, rr_ptr=0 -> grant order 0,1,2,3, then 0 again if still set.
REQ-040: Requester 3 continuous, requester 0 asserts later -> 0 granted no later than after one access by 3.
REQ-041: reset low during RESP of a read by requester 1 -> outputs 0 immediately, rsp_valid[1] never pulses, next grant searches from 0.
REQ-042: No requests for 10 cycles -> mem_write=0 and all req_ready/rsp_valid 0 throughout.
